// File: rtl/dsm_decim_ctrl.sv
// dsm_decim_ctrl: CIC decimation sequencer with settle discard and valid/ready output register
module dsm_decim_ctrl #(
    parameter int CIC_W      = 24,
    parameter int CAP_LAT    = 1,
    parameter int SETTLE_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       ratio_sel,
    input  logic [CIC_W-1:0] cic_data,
    output logic             int_en,
    output logic             comb_stb,
    output logic [CIC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             settled,
    output logic             overrun
);
    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;
    state_t state, state_nxt;
    logic [1:0]         rsel;
    logic [6:0]         phase, phase_nxt, rmax;
    logic [2:0]         disc;
    logic [CAP_LAT-1:0] pipe;
    logic               act, go, cap, load;
    assign rmax = {rsel == 2'd3, rsel[1], |rsel, 4'hf};
    assign act  = state != IDLE;
    assign go   = act && en;
    assign cap  = pipe[CAP_LAT-1];
    assign load = state == RUN && cap;
    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        phase_nxt = (go && phase != rmax) ? phase + 7'd1 : 7'd0;
        if (!act)
            state_nxt = en ? SETTLE : IDLE;
        else if (!en)
            state_nxt = IDLE;
        else if (state == SETTLE && (disc == 3'(SETTLE_CNT) || (cap && disc + 3'd1 == 3'(SETTLE_CNT))))
            state_nxt = RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rsel      <= 2'd0;
            phase     <= 7'd0;
            disc      <= 3'd0;
            pipe      <= '0;
            int_en    <= 1'b0;
            comb_stb  <= 1'b0;
            settled   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            int_en   <= state_nxt != IDLE;
            comb_stb <= go && phase_nxt == rmax;
            settled  <= state_nxt == RUN;
            pipe     <= go ? CAP_LAT'({pipe, comb_stb}) : '0;
            if (!act && en) begin
                rsel    <= ratio_sel;
                disc    <= 3'd0;
                overrun <= 1'b0;
            end else if (state == SETTLE && cap) begin
                disc <= disc + 3'd1;
            end
            if (load) begin
                out_data  <= cic_data;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) overrun <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
